// File: rtl/cmd_frame_pkg.sv
// Shared encodings for the command frame decoder: FSM states, rejection causes
// and command opcode nibbles.
package cmd_frame_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        DROP  = 3'd2,
        CHECK = 3'd3,
        EXEC  = 3'd4
    } state_t;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_BAD_HDR = 3'd1;
    localparam logic [2:0] ERR_LONG    = 3'd2;
    localparam logic [2:0] ERR_SHORT   = 3'd3;
    localparam logic [2:0] ERR_CKSUM   = 3'd4;
    localparam logic [2:0] ERR_TRAILER = 3'd5;
    localparam logic [2:0] ERR_ID      = 3'd6;
    localparam logic [2:0] ERR_REJECT  = 3'd7;

    localparam logic [3:0] OP_HOST      = 4'd1;
    localparam logic [3:0] OP_RESET     = 4'd2;
    localparam logic [3:0] OP_PWR_ON    = 4'd3;
    localparam logic [3:0] OP_PWR_OFF   = 4'd4;
    localparam logic [3:0] OP_RESET_ALL = 4'd5;

endpackage

// File: rtl/cmd_frame_decoder_reset_pulse_gen.sv
// Single-channel retriggerable reset pulse: high for exactly RESET_CYCLES
// cycles after the last trigger.
module reset_pulse_gen #(
    parameter logic [31:0] RESET_CYCLES = 32'd16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic trigger,
    output logic pulse
);

    logic [31:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (trigger) begin
            cnt <= RESET_CYCLES;
        end else if (cnt != '0) begin
            cnt <= cnt - 32'd1;
        end
    end

    assign pulse = (cnt != '0);

endmodule

// File: rtl/cmd_frame_decoder.sv
// Frame decoder for the redundant-CPU command link: gap-delimited frames are
// validated, then host-select / reset / power commands are executed.
module cmd_frame_decoder
    import cmd_frame_pkg::*;
#(
    parameter int          FRAME_LEN    = 8,
    parameter logic [7:0]  HDR0         = 8'hEB,
    parameter logic [7:0]  HDR1         = 8'h90,
    parameter logic [7:0]  TRL0         = 8'h09,
    parameter logic [7:0]  TRL1         = 8'hD7,
    parameter logic [7:0]  BOARD_ID     = 8'hAB,
    parameter int          N_CPU        = 2,
    parameter logic [31:0] RESET_CYCLES = 32'd16,
    parameter int          HOST_W       = $clog2(N_CPU)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    input  logic              frame_gap,
    output logic [HOST_W-1:0] host_sel,
    output logic              force_swi,
    output logic [N_CPU-1:0]  reset_out,
    output logic [N_CPU-1:0]  power_on,
    output logic              frame_ok,
    output logic              frame_err,
    output logic [2:0]        err_code,
    output logic [2:0]        state
);

    localparam logic [4:0] LEN = 5'(FRAME_LEN);

    state_t            st, st_nxt;
    logic [4:0]        cnt, cnt_nxt;
    logic [7:0]        fbuf [FRAME_LEN];
    logic              store_en;
    logic [2:0]        drop_code, drop_code_nxt, err_code_nxt;
    logic              frame_ok_nxt, frame_err_nxt, force_swi_nxt;
    logic [HOST_W-1:0] host_sel_nxt;
    logic [N_CPU-1:0]  power_on_nxt, rst_trig;
    logic              exec_ok;

    logic [7:0]        cksum;
    logic [2:0]        chk_code;
    logic [3:0]        op, tgt;
    logic [HOST_W-1:0] tgt_idx;
    logic              tgt_bad;

    assign state = st;

    // Frame validation; the if-chain gives the lowest failing code priority.
    always_comb begin
        cksum = '0;
        for (int i = 2; i <= FRAME_LEN - 3; i++) begin
            cksum = cksum + fbuf[i];
        end
        chk_code = ERR_NONE;
        if (fbuf[0] != HDR0 || fbuf[1] != HDR1) begin
            chk_code = ERR_BAD_HDR;
        end else if (cksum != 8'd0) begin
            chk_code = ERR_CKSUM;
        end else if (fbuf[FRAME_LEN-2] != TRL0 || fbuf[FRAME_LEN-1] != TRL1) begin
            chk_code = ERR_TRAILER;
        end else if (fbuf[3] != BOARD_ID) begin
            chk_code = ERR_ID;
        end
    end

    assign op      = fbuf[4][7:4];
    assign tgt     = fbuf[4][3:0];
    assign tgt_idx = tgt[HOST_W-1:0];
    assign tgt_bad = ({28'd0, tgt} >= 32'(N_CPU));

    always_comb begin
        st_nxt        = st;
        cnt_nxt       = cnt;
        store_en      = 1'b0;
        drop_code_nxt = drop_code;
        err_code_nxt  = err_code;
        frame_ok_nxt  = 1'b0;
        frame_err_nxt = 1'b0;
        force_swi_nxt = 1'b0;
        host_sel_nxt  = host_sel;
        power_on_nxt  = power_on;
        rst_trig      = '0;
        exec_ok       = 1'b0;

        case (st)
            IDLE: begin
                if (byte_valid) begin
                    if (byte_data == HDR0) begin
                        store_en = 1'b1;
                        cnt_nxt  = 5'd1;
                        st_nxt   = RECV;
                    end else begin
                        st_nxt        = DROP;
                        drop_code_nxt = ERR_BAD_HDR;
                    end
                end
            end

            RECV: begin
                if (byte_valid) begin
                    if (cnt == LEN) begin
                        st_nxt        = DROP;
                        drop_code_nxt = ERR_LONG;
                    end else begin
                        store_en = 1'b1;
                        cnt_nxt  = cnt + 5'd1;
                        if (cnt == 5'd1 && byte_data != HDR1) begin
                            st_nxt        = DROP;
                            drop_code_nxt = ERR_BAD_HDR;
                        end
                    end
                end
                // A gap alongside a byte is judged after that byte is counted.
                if (frame_gap) begin
                    if (st_nxt == DROP) begin
                        st_nxt        = IDLE;
                        frame_err_nxt = 1'b1;
                        err_code_nxt  = drop_code_nxt;
                    end else if (cnt_nxt == LEN) begin
                        st_nxt = CHECK;
                    end else begin
                        st_nxt        = IDLE;
                        frame_err_nxt = 1'b1;
                        err_code_nxt  = ERR_SHORT;
                    end
                end
            end

            DROP: begin
                if (frame_gap) begin
                    st_nxt        = IDLE;
                    frame_err_nxt = 1'b1;
                    err_code_nxt  = drop_code;
                end
            end

            CHECK: begin
                if (chk_code == ERR_NONE) begin
                    st_nxt = EXEC;
                end else begin
                    st_nxt        = IDLE;
                    frame_err_nxt = 1'b1;
                    err_code_nxt  = chk_code;
                end
            end

            EXEC: begin
                st_nxt = IDLE;
                if (!tgt_bad) begin
                    case (op)
                        OP_HOST: begin
                            exec_ok       = 1'b1;
                            host_sel_nxt  = tgt_idx;
                            force_swi_nxt = 1'b1;
                        end
                        OP_RESET: begin
                            if (tgt_idx != host_sel) begin
                                exec_ok           = 1'b1;
                                rst_trig[tgt_idx] = 1'b1;
                            end
                        end
                        OP_PWR_ON: begin
                            exec_ok               = 1'b1;
                            power_on_nxt[tgt_idx] = 1'b1;
                            host_sel_nxt          = tgt_idx;
                            force_swi_nxt         = 1'b1;
                        end
                        OP_PWR_OFF: begin
                            if (tgt_idx != host_sel) begin
                                exec_ok               = 1'b1;
                                power_on_nxt[tgt_idx] = 1'b0;
                            end
                        end
                        OP_RESET_ALL: begin
                            exec_ok       = 1'b1;
                            rst_trig      = '1;
                            host_sel_nxt  = tgt_idx;
                            force_swi_nxt = 1'b1;
                        end
                        default: exec_ok = 1'b0;
                    endcase
                end
                if (exec_ok) begin
                    frame_ok_nxt = 1'b1;
                    err_code_nxt = ERR_NONE;
                end else begin
                    frame_err_nxt = 1'b1;
                    err_code_nxt  = ERR_REJECT;
                end
            end

            default: st_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= IDLE;
            cnt       <= '0;
            drop_code <= ERR_NONE;
            err_code  <= ERR_NONE;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            force_swi <= 1'b0;
            host_sel  <= '0;
            power_on  <= '1;
        end else begin
            st        <= st_nxt;
            cnt       <= cnt_nxt;
            drop_code <= drop_code_nxt;
            err_code  <= err_code_nxt;
            frame_ok  <= frame_ok_nxt;
            frame_err <= frame_err_nxt;
            force_swi <= force_swi_nxt;
            host_sel  <= host_sel_nxt;
            power_on  <= power_on_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FRAME_LEN; i++) fbuf[i] <= '0;
        end else if (store_en) begin
            for (int i = 0; i < FRAME_LEN; i++) begin
                if (cnt == 5'(i)) fbuf[i] <= byte_data;
            end
        end
    end

    for (genvar g = 0; g < N_CPU; g++) begin : g_rst
        reset_pulse_gen #(
            .RESET_CYCLES(RESET_CYCLES)
        ) u_pulse (
            .clk    (clk),
            .rst_n  (rst_n),
            .trigger(rst_trig[g]),
            .pulse  (reset_out[g])
        );
    end

endmodule
